toggle_req_ctrl: RTL
====================

# toggle_req_ctrl

Multi-channel toggle-handshake request generator for the source side of handshake clock-domain crossings, one per crossing bundle. Each channel converts single-cycle event pulses into toggles on a request line. It holds off the next toggle until the far side returns a matching acknowledge toggle, which is already synchronised into this clock. A per-channel saturating pending counter queues events that arrive while a handshake is in flight, so bursts are not lost.

## Interface
- CH, 4: number of independent channels (1..32)
- CNT_W, 3: pending-counter width; max queued events = 2^CNT_W-1
- clk  input  1  sole clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en_i  input  CH  per-channel event enable; evt_i ignored when low
- evt_i  input  CH  single-cycle event pulses
- ack_tgl_i  input  CH  acknowledge toggles, already synchronised into clk
- ovf_clr_i  input  1  clears all ovf_o bits
- req_tgl_o  output  CH  request toggles to the far domain
- busy_o  output  CH  handshake in flight (state WAIT_ACK)
- pend_cnt_o  output  CH*CNT_W  queued events; channel i at bits [i*CNT_W +: CNT_W]
- ovf_o  output  CH  sticky: an event was dropped at saturation

## Operation
- Reset: all outputs are 0. Channel state is IDLE. Reset is asynchronous, and asserting it mid-handshake abandons the handshake; the far side must also be reset.
- Accepted event: evt_i[i] & en_i[i].
- Ack match: ack_tgl_i[i] == req_tgl_o[i].
- Per-channel FSM, states IDLE and WAIT_ACK:
  - IDLE: if an accepted event occurs or cnt>0, toggle req and go to WAIT_ACK. ack_tgl_i is ignored in IDLE.
  - WAIT_ACK on ack match with cnt>0 or an accepted event: toggle req again and stay in WAIT_ACK.
  - WAIT_ACK on ack match with no work: go to IDLE.
  - WAIT_ACK with no match: hold.
- Issue: the cycle in which req toggles.
- Counter update per cycle: cnt_next = cnt + accepted - issue_from_cnt.
  - An accepted event in an issue cycle with cnt==0 is issued directly and never counted.
  - If cnt>0, the issue takes from cnt and the event increments it, for a net change of 0.
- Saturation: if cnt == 2^CNT_W-1 and an accepted event arrives with no issue, cnt holds, the event is dropped, and ovf_o[i] is set.
- ovf_clr_i clears ovf_o. If clear and set occur in the same cycle, set wins.
- Channels are fully independent; only ovf_clr_i is shared.

## Timing
- Latency from an accepted event in IDLE (sampled at edge k) to a req toggle visible after edge k is 1 edge; busy_o rises on the same edge.
- An ack match sampled at edge m with queued work gives the next toggle after edge m, with no idle cycle. The minimum toggle spacing therefore equals the ack round-trip.
- Without queued work, busy_o falls after edge m. A new event can then issue at edge m+1.
- pend_cnt_o and ovf_o are registered and update on the same edge as the event that changes them.
- No combinational path exists from any input to any output.

## Structure
- Package toggle_req_pkg holds:
  - the state enum (IDLE, WAIT_ACK)
  - a function that returns max count for a given CNT_W
- Sub-module toggle_req_chan implements one channel: FSM, req flop, counter, ovf flop. The top instantiates CH copies with a generate loop and concatenates pend_cnt_o.
- Keep all flops in the source domain. This block does not synchronise ack; synchronisers sit outside.

## Test plan
- Single event: CH=4, pulse evt_i[0] with en_i=1 → req_tgl_o[0] goes 0→1 after 1 edge and busy_o[0]=1. Drive ack_tgl_i[0]=1 five cycles later → busy_o[0]=0 on the next edge; channels 1-3 stay unchanged.
- Burst: 4 back-to-back events on channel 1 with ack returned 6 cycles after each toggle → pend_cnt goes 0,1,2,3. req toggles exactly 4 times, each toggle in the same cycle the ack matches. cnt returns to 0, ovf_o stays 0.
- Saturation: CNT_W=3, channel held in WAIT_ACK, 9 events → cnt stops at 7 and ovf_o[2]=1. Pulse ovf_clr_i alone → ovf_o clears; pulse ovf_clr_i together with a further event → ovf_o stays 1.
- Simultaneous: with cnt=2, drive an event and an ack match in the same cycle → req toggles and cnt stays 2.
- Enable/idle ack: en_i[3]=0 with 3 events → nothing issued, cnt=0. An ack_tgl_i[3] toggle while in IDLE → no effect.
- Reset mid-operation: assert rst_n=0 with cnt=5 and busy=1, asynchronously mid-cycle → all outputs read 0 immediately. After release, a fresh event issues with 1-edge latency.

Source files
------------

// File: rtl/toggle_req_pkg.sv
// Shared types and helpers for the toggle-handshake request generator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package toggle_req_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    // Largest value a pending counter of width w can hold.
    function automatic int unsigned max_cnt(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/toggle_req_chan.sv
// One toggle-handshake channel: event pulses become req toggles, one per ack round-trip.
// Latency: accepted event in IDLE toggles req after 1 edge; ack match with work re-toggles after 1 edge.
// Backpressure: events arriving mid-handshake queue in a saturating counter; overflow drops and flags ovf_o.
module toggle_req_chan
    import toggle_req_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             evt_i,
    input  logic             ack_tgl_i,
    input  logic             ovf_clr_i,
    output logic             req_tgl_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pend_cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_cnt(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic accepted;
    logic ack_match;
    logic have_work;
    logic issue;
    logic drop;

    assign accepted  = evt_i & en_i;
    assign ack_match = (ack_tgl_i == req_q);
    assign have_work = accepted | (cnt_q != '0);

    // Next state, issue decision and queue accounting for this cycle.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        drop    = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // ack is meaningless here; the far side has nothing outstanding.
                if (have_work) begin
                    issue   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_match) begin
                    if (have_work) begin
                        issue = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue && (cnt_q != '0)) begin
            // Issue drains one queued event; a coincident event refills it.
            cnt_d = accepted ? cnt_q : (cnt_q - CNT_ONE);
        end else if (accepted && !issue) begin
            if (cnt_q == CNT_MAX) begin
                drop = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        // accepted && issue && cnt==0: the event goes straight out, never counted.

        req_d = req_q ^ issue;
        ovf_d = (ovf_q & ~ovf_clr_i) | drop;
    end

    // Channel registers; reset abandons any handshake in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign req_tgl_o  = req_q;
    assign busy_o     = (state_q == WAIT_ACK);
    assign pend_cnt_o = cnt_q;
    assign ovf_o      = ovf_q;

endmodule

// File: rtl/toggle_req_ctrl.sv
// Multi-channel toggle-handshake request generator for the source side of CDC bundles.
// Latency: 1 edge from accepted event (or ack match with queued work) to req toggle; all outputs registered.
// Backpressure: each channel queues up to 2^CNT_W-1 events while waiting for ack; excess sets sticky ovf_o.
module toggle_req_ctrl
    import toggle_req_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       en_i,
    input  logic [CH-1:0]       evt_i,
    input  logic [CH-1:0]       ack_tgl_i,
    input  logic                ovf_clr_i,
    output logic [CH-1:0]       req_tgl_o,
    output logic [CH-1:0]       busy_o,
    output logic [CH*CNT_W-1:0] pend_cnt_o,
    output logic [CH-1:0]       ovf_o
);

    // Channels are independent; only the overflow clear is shared.
    for (genvar i = 0; i < CH; i++) begin : g_chan
        toggle_req_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (en_i[i]),
            .evt_i      (evt_i[i]),
            .ack_tgl_i  (ack_tgl_i[i]),
            .ovf_clr_i  (ovf_clr_i),
            .req_tgl_o  (req_tgl_o[i]),
            .busy_o     (busy_o[i]),
            .pend_cnt_o (pend_cnt_o[i*CNT_W +: CNT_W]),
            .ovf_o      (ovf_o[i])
        );
    end

endmodule
